// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution sequencer.
package conv_seq_pkg;

  // Kernel weight count held by the engine's weight register.
  localparam int unsigned NUM_W = 25;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_W   = 3'd1,
    ST_STREAM_X = 3'd2,
    ST_WAIT_Y   = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // Number of engine results produced for one feature map.
  function automatic int unsigned out_n(input int unsigned img_w,
                                        input int unsigned k,
                                        input int unsigned stride);
    int unsigned side;
    side = (img_w - k) / stride + 1;
    return side * side;
  endfunction

endpackage

// File: rtl/conv_seq_counter.sv
// Up-counter with synchronous clear, enable and a registered terminal-count flag.
module seq_counter #(
  parameter int unsigned W   = 8,
  parameter int unsigned MAX = 255
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] q_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc_q, tc_d;

  // Next count and whether it lands on the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
    tc_d = (cnt_d == W'(MAX));
  end

  // Count and flag registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tc_q  <= (MAX == 0);
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign q_o  = cnt_q;
  assign tc_o = tc_q;

endmodule

// File: rtl/conv_sequencer.sv
// Sequences weight load, pixel streaming and result write-back for the 5x5 conv engine.
module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned K      = 5,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 16
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iStart,
  input  logic [AW-1:0] iWBase,
  input  logic [AW-1:0] iXBase,
  output logic [AW-1:0] oMemAddr,
  output logic          oMemRen,
  input  logic [DW-1:0] iMemData,
  output logic [DW-1:0] oConvW,
  output logic [9:0]    oConvADDR,
  output logic          oConvWren,
  output logic [DW-1:0] oConvX,
  output logic          oConvValid,
  input  logic [DW-1:0] iConvY,
  input  logic          iConvValid,
  output logic [AW-1:0] oOutAddr,
  output logic [DW-1:0] oOutData,
  output logic          oOutWe,
  output logic          oBusy,
  output logic          oDone
);

  localparam int unsigned OUT_N = out_n(IMG_W, K, STRIDE);
  localparam int unsigned NUM_X = IMG_W * IMG_W;
  localparam int unsigned WC_W  = $clog2(NUM_W);
  localparam int unsigned XC_W  = $clog2(NUM_X);
  localparam int unsigned OC_W  = $clog2(OUT_N + 1);

  state_e        state_q, state_d;
  logic [AW-1:0] wbase_q, xbase_q;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_ren_q, mem_ren_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wr_v_q, px_v_q;
  logic [9:0]    widx_q;
  logic          out_we_q;
  logic [AW-1:0] out_addr_q;
  logic [DW-1:0] out_data_q;

  logic [WC_W-1:0] wcnt;
  logic [XC_W-1:0] xcnt;
  logic [OC_W-1:0] ocnt;
  logic            wtc, xtc, otc;
  logic            start_c, cap_c;

  assign start_c = (state_q == ST_IDLE) && iStart;
  assign cap_c   = (state_q != ST_IDLE) && iConvValid && !otc;

  seq_counter #(.W(WC_W), .MAX(NUM_W - 1)) u_wcnt (
    .clk_i (iCLK), .rst_ni(iRSTn), .clr_i(start_c),
    .en_i  ((state_q == ST_LOAD_W) && !wtc),
    .q_o   (wcnt), .tc_o(wtc)
  );

  seq_counter #(.W(XC_W), .MAX(NUM_X - 1)) u_xcnt (
    .clk_i (iCLK), .rst_ni(iRSTn), .clr_i(start_c),
    .en_i  ((state_q == ST_STREAM_X) && !xtc),
    .q_o   (xcnt), .tc_o(xtc)
  );

  seq_counter #(.W(OC_W), .MAX(OUT_N)) u_ocnt (
    .clk_i (iCLK), .rst_ni(iRSTn), .clr_i(start_c),
    .en_i  (cap_c),
    .q_o   (ocnt), .tc_o(otc)
  );

  // Next state plus the read request and status presented in the next cycle.
  always_comb begin
    state_d    = state_q;
    mem_ren_d  = 1'b0;
    mem_addr_d = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          state_d    = ST_LOAD_W;
          mem_ren_d  = 1'b1;
          mem_addr_d = iWBase;
          busy_d     = 1'b1;
        end
      end
      ST_LOAD_W: begin
        busy_d    = 1'b1;
        mem_ren_d = 1'b1;
        if (wtc) begin
          state_d    = ST_STREAM_X;
          mem_addr_d = xbase_q;
        end else begin
          mem_addr_d = wbase_q + AW'(wcnt) + AW'(1);
        end
      end
      ST_STREAM_X: begin
        busy_d = 1'b1;
        if (xtc) begin
          state_d = ST_WAIT_Y;
        end else begin
          mem_ren_d  = 1'b1;
          mem_addr_d = xbase_q + AW'(xcnt) + AW'(1);
        end
      end
      ST_WAIT_Y: begin
        // otc means the last write is on the output port this cycle.
        if (otc) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, read port, status and the one-cycle read-return pipes.
  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      state_q    <= ST_IDLE;
      wbase_q    <= '0;
      xbase_q    <= '0;
      mem_ren_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_v_q     <= 1'b0;
      px_v_q     <= 1'b0;
      widx_q     <= '0;
    end else begin
      state_q    <= state_d;
      mem_ren_q  <= mem_ren_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      if (start_c) begin
        wbase_q <= iWBase;
        xbase_q <= iXBase;
      end
      wr_v_q <= mem_ren_q && (state_q == ST_LOAD_W);
      px_v_q <= mem_ren_q && (state_q == ST_STREAM_X);
      widx_q <= 10'(wcnt);
    end
  end

  // Result write-back, one cycle behind the sampled engine valid.
  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      out_we_q <= cap_c;
      if (cap_c) begin
        out_addr_q <= AW'(ocnt);
        out_data_q <= iConvY;
      end
    end
  end

  assign oMemRen    = mem_ren_q;
  assign oMemAddr   = mem_addr_q;
  assign oConvWren  = wr_v_q;
  assign oConvADDR  = widx_q;
  assign oConvW     = wr_v_q ? iMemData : '0;
  assign oConvValid = px_v_q;
  assign oConvX     = px_v_q ? iMemData : '0;
  assign oOutWe     = out_we_q;
  assign oOutAddr   = out_addr_q;
  assign oOutData   = out_data_q;
  assign oBusy      = busy_q;
  assign oDone      = done_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: memory model, scripted engine, cycle-accurate monitor.
`timescale 1ns/1ps
module tb_conv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iStart;
  logic [15:0] iWBase, iXBase;
  logic [15:0] oMemAddr;
  logic        oMemRen;
  logic [31:0] iMemData;
  logic [31:0] oConvW;
  logic [9:0]  oConvADDR;
  logic        oConvWren;
  logic [31:0] oConvX;
  logic        oConvValid;
  logic [31:0] iConvY;
  logic        iConvValid;
  logic [15:0] oOutAddr;
  logic [31:0] oOutData;
  logic        oOutWe;
  logic        oBusy;
  logic        oDone;

  logic [31:0] mem [0:65535];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // run-tracking state shared with the monitor
  bit          mon_en = 1'b0;
  bit          run_active = 1'b0;
  int          start_cyc, j;
  int          rexp, wexp, pexp, oexp, done_cnt, done_j, last_we_j;
  logic        prev_busy;
  logic [15:0] wbase_e, xbase_e, exp_a;
  int          wval_base;

  conv_sequencer dut (
    .iCLK      (clk),
    .iRSTn     (rst_n),
    .iStart    (iStart),
    .iWBase    (iWBase),
    .iXBase    (iXBase),
    .oMemAddr  (oMemAddr),
    .oMemRen   (oMemRen),
    .iMemData  (iMemData),
    .oConvW    (oConvW),
    .oConvADDR (oConvADDR),
    .oConvWren (oConvWren),
    .oConvX    (oConvX),
    .oConvValid(oConvValid),
    .iConvY    (iConvY),
    .iConvValid(iConvValid),
    .oOutAddr  (oOutAddr),
    .oOutData  (oOutData),
    .oOutWe    (oOutWe),
    .oBusy     (oBusy),
    .oDone     (oDone)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read source memory, data one cycle after the request
  always @(posedge clk) if (oMemRen) iMemData <= mem[oMemAddr];

  function automatic logic [31:0] res_val(input int i);
    return 32'(i * 7) - 32'd1000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_zero(input string p);
    chk({p, "_ren"},   32'(oMemRen), 0);
    chk({p, "_addr"},  32'(oMemAddr), 0);
    chk({p, "_wren"},  32'(oConvWren), 0);
    chk({p, "_wadr"},  32'(oConvADDR), 0);
    chk({p, "_w"},     oConvW, 0);
    chk({p, "_xv"},    32'(oConvValid), 0);
    chk({p, "_x"},     oConvX, 0);
    chk({p, "_we"},    32'(oOutWe), 0);
    chk({p, "_oaddr"}, 32'(oOutAddr), 0);
    chk({p, "_odata"}, oOutData, 0);
    chk({p, "_busy"},  32'(oBusy), 0);
    chk({p, "_done"},  32'(oDone), 0);
  endtask

  // cycle-by-cycle expectations against the run's start edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (run_active) begin
        j = cyc - start_cyc + 1;
        if (oMemRen) begin
          exp_a = (rexp < 25) ? 16'(32'(wbase_e) + rexp) : 16'(32'(xbase_e) + rexp - 25);
          chk("rd_addr", 32'(oMemAddr), 32'(exp_a));
          chk("rd_time", 32'(j), 32'(1 + rexp));
          rexp++;
        end
        if (oConvWren) begin
          chk("w_idx",  32'(oConvADDR), 32'(wexp));
          chk("w_data", oConvW, 32'(wval_base + wexp));
          chk("w_time", 32'(j), 32'(2 + wexp));
          wexp++;
        end
        if (oConvValid) begin
          chk("x_data", oConvX, 32'(pexp));
          chk("x_time", 32'(j), 32'(27 + pexp));
          pexp++;
        end
        if (oOutWe) begin
          chk("o_addr", 32'(oOutAddr), 32'(oexp));
          chk("o_data", oOutData, res_val(oexp));
          oexp++;
          last_we_j = j;
        end
        if (oDone) begin
          chk("done_busy", 32'(oBusy), 0);
          chk("busy_pre_done", 32'(prev_busy), 1);
          done_cnt++;
          done_j = j;
        end else begin
          chk("busy", 32'(oBusy), 1);
        end
        prev_busy = oBusy;
      end else begin
        chk("idle_quiet", 32'({oMemRen, oConvWren, oConvValid, oOutWe, oBusy, oDone}), 0);
      end
    end
  end

  task automatic start_run(input logic [15:0] wb, input logic [15:0] xb, input int wv);
    @(negedge clk);
    iStart = 1'b1;
    iWBase = wb;
    iXBase = xb;
    wbase_e = wb;
    xbase_e = xb;
    wval_base = wv;
    @(posedge clk);
    #1;
    iStart = 1'b0;
    start_cyc = cyc;
    rexp = 0; wexp = 0; pexp = 0; oexp = 0;
    done_cnt = 0; done_j = 0; last_we_j = 0;
    prev_busy = 1'b0;
    run_active = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      seen = oDone;
    end
    #1;
    chk("done_seen", 32'(seen), 1);
    run_active = 1'b0;
  endtask

  task automatic engine(input int delay, input int count);
    int i = 0;
    int c = 0;
    repeat (delay) @(negedge clk);
    while (i < count) begin
      @(negedge clk);
      if ((c % 9) < 7) begin
        iConvValid = 1'b1;
        iConvY = res_val(i);
        i++;
      end else begin
        iConvValid = 1'b0;
      end
      c++;
    end
    @(negedge clk);
    iConvValid = 1'b0;
  endtask

  task automatic spam_start(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      iStart = c[0];
      iWBase = 16'h3333;
      iXBase = 16'h5555;
    end
    iStart = 1'b0;
  endtask

  task automatic end_run(input string name);
    chk({name, "_n_rd"}, 32'(rexp), 1049);
    chk({name, "_n_w"},  32'(wexp), 25);
    chk({name, "_n_x"},  32'(pexp), 1024);
    chk({name, "_n_out"}, 32'(oexp), 784);
    chk({name, "_n_done"}, 32'(done_cnt), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 32'd0;
    for (int k = 0; k < 25; k++) begin
      mem[16'h0100 + k] = 32'(k + 1);
      mem[16'(32'hFFF0 + k)] = 32'(100 + k);
    end
    for (int n = 0; n < 1024; n++) mem[16'h0400 + n] = 32'(n);

    rst_n = 1'b0; iStart = 1'b0; iWBase = '0; iXBase = '0;
    iConvValid = 1'b0; iConvY = '0; iMemData = '0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // A: weights 1..25, pixels 0..1023, start ignored while busy, results end in WAIT_Y
    start_run(16'h0100, 16'h0400, 1);
    fork
      engine(300, 784);
      spam_start(600);
      wait_done(3000);
    join
    end_run("A");
    chk("A_done_after_last_we", 32'(done_j), 32'(last_we_j + 1));

    // B: restart on the cycle after done, wrapping weight base, results finish during stream
    start_run(16'hFFF0, 16'h0400, 100);
    fork
      engine(0, 784);
      wait_done(3000);
    join
    end_run("B");
    chk("B_done_time", 32'(done_j), 1051);

    // C: reset mid-stream abandons the run
    start_run(16'h0100, 16'h0400, 1);
    for (int n = 0; n < 500 && pexp < 100; n++) @(negedge clk);
    chk("C_streaming", 32'(pexp >= 100), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    run_active = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst_n = 1'b1;
    iConvValid = 1'b1;
    iConvY = 32'd123;
    repeat (6) @(negedge clk);
    iConvValid = 1'b0;
    chk("C_no_we", 32'(oOutWe), 0);
    repeat (4) @(negedge clk);

    // D: fresh run after reset, surplus engine results discarded
    start_run(16'h0100, 16'h0400, 1);
    fork
      engine(50, 792);
      wait_done(3000);
    join
    end_run("D");
    chk("D_done_after_last_we", 32'(done_j), 32'(last_we_j + 1));
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Top-level controller for the 5x5 convolution engine. On a start pulse it fetches the 25 kernel weights from a source memory into the engine's weight register, streams one IMG_W×IMG_W feature map into the engine at one pixel per cycle, and writes each engine result to an output memory at consecutive addresses. It then pulses done. It sits between the shared on-chip SRAM ports and the convolution engine's weight-load, pixel and result ports.

## Interface
- IMG_W, 32, input feature-map side length in pixels; must be ≥ K
- K, 5, kernel side; fixed at 5 to match the engine's 25-entry weight register
- STRIDE, 1, engine stride; used only to compute the expected output count
- DW, 32, data width (signed)
- AW, 16, memory address width

Ports:
- iCLK  in  1  clock
- iRSTn  in  1  reset, synchronous, active-low
- iStart  in  1  one-cycle start request; ignored while oBusy=1
- iWBase  in  AW  source address of weight 0; captured on accepted iStart
- iXBase  in  AW  source address of pixel 0 (row-major); captured on accepted iStart
- oMemAddr  out  AW  source memory read address
- oMemRen  out  1  source memory read enable; data returns on iMemData exactly one cycle later
- iMemData  in  DW  source memory read data
- oConvW  out  DW  weight data to engine
- oConvADDR  out  10  weight index to engine, 0..24
- oConvWren  out  1  weight write strobe
- oConvX  out  DW  pixel to engine
- oConvValid  out  1  pixel valid to engine
- iConvY  in  DW  engine result
- iConvValid  in  1  engine result valid
- oOutAddr  out  AW  output memory write address (0-based)
- oOutData  out  DW  output memory write data
- oOutWe  out  1  output memory write enable
- oBusy  out  1  high from the cycle after an accepted iStart until the cycle oDone is high
- oDone  out  1  one-cycle completion pulse

## Operation
- OUT_N = ((IMG_W−K)/STRIDE+1)², using integer division. Defaults give 784.
- FSM states: IDLE → LOAD_W → STREAM_X → WAIT_Y → DONE → IDLE.
- IDLE: the cycle when iStart=1 is sampled captures both base addresses, clears all counters, and enters LOAD_W.
- LOAD_W: 25 cycles. On cycle k (0..24) drive oMemRen=1 and oMemAddr=iWBase+k. One cycle later drive oConvWren=1, oConvADDR=k and oConvW=iMemData. After k=24 go to STREAM_X.
- STREAM_X: IMG_W² cycles. On cycle n drive oMemRen=1 and oMemAddr=iXBase+n. One cycle later drive oConvValid=1 and oConvX=iMemData. After the last read go to WAIT_Y.
- Result capture runs in every non-IDLE state. When iConvValid=1, the next cycle drives oOutWe=1, oOutData=iConvY and oOutAddr=out_cnt, and out_cnt increments. Results beyond OUT_N are discarded (no write).
- WAIT_Y: stay until out_cnt=OUT_N and the final write has been issued, then go to DONE.
- DONE: oDone=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^AW, so base+offset wraps silently.
- iStart while busy has no effect and is not queued.

## Timing
- Reset (iRSTn=0 at a rising edge): state=IDLE, all counters 0, every output 0. This applies equally in mid-operation: a partial load or stream is abandoned and no further writes are issued.
- Accepted iStart at edge t: oBusy=1 and the first weight read occur at t+1.
- Weight writes occur at t+2..t+26.
- Pixel reads occur at t+26..t+25+IMG_W². The first oConvValid is at t+27, so it overlaps the last weight write by zero cycles.
- Output write latency is 1 cycle from the sampled iConvValid.
- Same-cycle completion: if the last iConvValid arrives during STREAM_X, WAIT_Y is still entered for at least one cycle.
- oDone and oBusy are never high in the same cycle.
- A new iStart is accepted in the cycle after oDone.

## Structure
- Package conv_seq_pkg holds:
  - the state enum
  - constant NUM_W=25
  - function out_n(IMG_W, K, STRIDE)
- One sub-module, seq_counter (parameterised width, sync clear, enable, terminal-count flag), instantiated for weight index, pixel index and output count.
- The 1-cycle read-return alignment lives in the top level as registered valid/index pipes.

## Test plan
- Reset then iStart with iWBase=0x100, weights w[k]=k+1 → oConvWren at t+2..t+26 with oConvADDR=0..24 and oConvW=1..25, no gaps.
- IMG_W=32 stream from iXBase=0x400, with memory holding pixel n=n → 1024 oConvValid cycles carrying 0..1023 contiguously from t+27; oMemAddr=0x400..0x7FF.
- Engine model returns 784 results with iConvValid bursts and gaps → 784 oOutWe pulses, oOutAddr 0..783 in order, data matching; oDone pulses once and oBusy drops with it.
- iStart asserted repeatedly during LOAD_W and STREAM_X → ignored, base registers unchanged; iStart on the cycle after oDone → new run begins.
- iRSTn low for one cycle mid-STREAM_X → all outputs 0 next cycle, FSM IDLE, no writes until a fresh iStart.
- iWBase=0xFFF0 → weight reads wrap to 0x0000..0x0008 after 0xFFFF.
